sr_vector_reg: RTL and testbench

Parametrised successor to the single-bit set/reset flip-flop: a WIDTH-bit register with per-bit synchronous set/reset override and a mode-selected hold/load/shift data path. A 2-bit `MODE` input selects the data path, and a parameter selects how simultaneous set and reset on one bit is resolved. It sits in the lab datapath wherever a bank of S/R flip-flops was previously instantiated bit by bit. It also reports set/reset conflicts through a registered flag and a saturating counter.

---
 rtl/sr_vector_pkg.sv | 15 +
 rtl/sr_bit_cell.sv | 52 +++++
 rtl/sr_vector_reg.sv | 78 +++++++
 tb/tb_sr_vector_reg.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sr_vector_pkg.sv
// Shared constants for the vector S/R register: data-path modes and the
// policies for resolving a bit that sees set and reset together.
package sr_vector_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    localparam int CONF_RST  = 0;
    localparam int CONF_SET  = 1;
    localparam int CONF_HOLD = 2;
    localparam int CONF_BOTH = 3;

endpackage

// File: rtl/sr_bit_cell.sv
// One S/R bit: conflict policy, then reset, then set, then the mode result.
module sr_bit_cell
    import sr_vector_pkg::*;
#(
    parameter int CONFLICT_MODE = CONF_BOTH
) (
    input  logic CLK,
    input  logic RN,
    input  logic R,
    input  logic S,
    input  logic M,
    output logic Q,
    output logic QN
);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            Q  <= 1'b0;
            QN <= 1'b1;
        end else if (R && S) begin
            case (CONFLICT_MODE)
                CONF_RST: begin
                    Q  <= 1'b0;
                    QN <= 1'b1;
                end
                CONF_SET: begin
                    Q  <= 1'b1;
                    QN <= 1'b0;
                end
                CONF_HOLD: begin
                    Q  <= Q;
                    QN <= QN;
                end
                default: begin
                    Q  <= 1'b1;
                    QN <= 1'b1;
                end
            endcase
        end else if (R) begin
            Q  <= 1'b0;
            QN <= 1'b1;
        end else if (S) begin
            Q  <= 1'b1;
            QN <= 1'b0;
        end else begin
            // QN is always rebuilt from M, so hold repairs a (1,1) pair.
            Q  <= M;
            QN <= ~M;
        end
    end

endmodule

// File: rtl/sr_vector_reg.sv
// WIDTH-bit bank of S/R flip-flops with hold/load/shift data path and a
// registered conflict flag plus saturating conflict counter.
module sr_vector_reg
    import sr_vector_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int CONFLICT_MODE = 3,
    parameter int CNT_W         = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       MODE,
    input  logic             SIN,
    input  logic             CLR_CNT,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic [WIDTH-1:0] VAL,
    output logic             CONFLICT,
    output logic [CNT_W-1:0] CONF_CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] m;
    logic             any_conf;

    // Mode result always derives from registered Q; QN never shifts.
    always_comb begin
        m = Q;
        case (MODE)
            MODE_HOLD: m = Q;
            MODE_LOAD: m = D;
            MODE_SHL:  m = {Q[WIDTH-2:0], SIN};
            MODE_SHR:  m = {SIN, Q[WIDTH-1:1]};
            default:   m = Q;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr_bit_cell #(
            .CONFLICT_MODE(CONFLICT_MODE)
        ) u_cell (
            .CLK (CLK),
            .RN  (RN),
            .R   (R[i]),
            .S   (S[i]),
            .M   (m[i]),
            .Q   (Q[i]),
            .QN  (QN[i])
        );
    end

    assign any_conf = |(R & S);
    assign VAL      = Q ^ QN;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            CONFLICT <= 1'b0;
            CONF_CNT <= '0;
        end else begin
            CONFLICT <= any_conf;
            // Clear wins over a same-cycle conflict; count saturates.
            if (CLR_CNT)
                CONF_CNT <= '0;
            else if (any_conf && CONF_CNT != CNT_MAX)
                CONF_CNT <= CONF_CNT + 1'b1;
        end
    end

    always @(posedge CLK) begin
        if (RN)
            assert (!$isunknown(MODE)) else $error("sr_vector_reg: MODE is X/Z");
    end

endmodule

// File: tb/tb_sr_vector_reg.sv
// Directed bench: one instance per conflict policy, all driven in parallel.
module tb_sr_vector_reg;

    logic       CLK = 1'b0;
    logic       RN;
    logic [7:0] R, S, D;
    logic [1:0] MODE;
    logic       SIN, CLR_CNT;

    logic [7:0] q [4];
    logic [7:0] qn[4];
    logic [7:0] val[4];
    logic       conf[4];
    logic [3:0] cnt[4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        sr_vector_reg #(.WIDTH(8), .CONFLICT_MODE(k), .CNT_W(4)) u_dut (
            .CLK      (CLK),
            .RN       (RN),
            .R        (R),
            .S        (S),
            .D        (D),
            .MODE     (MODE),
            .SIN      (SIN),
            .CLR_CNT  (CLR_CNT),
            .Q        (q[k]),
            .QN       (qn[k]),
            .VAL      (val[k]),
            .CONFLICT (conf[k]),
            .CONF_CNT (cnt[k])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] md, input logic [7:0] d, input logic [7:0] r,
                         input logic [7:0] s, input logic sin);
        MODE = md; D = d; R = r; S = s; SIN = sin;
    endtask

    initial begin
        RN = 1'b0; R = '0; S = '0; D = '0; MODE = 2'b00; SIN = 1'b0; CLR_CNT = 1'b0;
        #12;
        chk("rst_q",    q[3], 8'h00);
        chk("rst_qn",   qn[3], 8'hFF);
        chk("rst_val",  val[3], 8'hFF);
        chk("rst_conf", conf[3], 1'b0);
        chk("rst_cnt",  cnt[3], 4'd0);
        @(posedge CLK); #1 RN = 1'b1;

        drive(2'b01, 8'hA5, 8'h00, 8'h00, 1'b0); tick();
        chk("load_q",  q[3], 8'hA5);
        chk("load_qn", qn[3], 8'h5A);

        // Asynchronous reset mid-cycle, no edge needed
        #2 RN = 1'b0; #1;
        chk("arst_q",   q[3], 8'h00);
        chk("arst_qn",  qn[3], 8'hFF);
        chk("arst_val", val[3], 8'hFF);
        @(posedge CLK); #1 RN = 1'b1;

        drive(2'b01, 8'h81, 8'h00, 8'h00, 1'b0); tick();
        chk("pre_shl", q[3], 8'h81);
        drive(2'b10, 8'h00, 8'h00, 8'h00, 1'b1); tick();
        chk("shl1", q[3], 8'h03);
        tick();
        chk("shl2", q[3], 8'h07);
        chk("shl2_qn", qn[3], 8'hF8);
        drive(2'b11, 8'h00, 8'h00, 8'h00, 1'b0); tick();
        chk("shr", q[3], 8'h03);

        drive(2'b01, 8'hFF, 8'h0F, 8'h00, 1'b0); tick();
        chk("ovr_q",    q[3], 8'hF0);
        chk("ovr_qn",   qn[3], 8'h0F);
        chk("ovr_conf", conf[3], 1'b0);

        drive(2'b01, 8'h00, 8'h01, 8'h02, 1'b0); tick();
        chk("rs_diff_q",    q[3], 8'h02);
        chk("rs_diff_qn",   qn[3], 8'hFD);
        chk("rs_diff_conf", conf[3], 1'b0);

        drive(2'b01, 8'h01, 8'h00, 8'h00, 1'b0); tick();
        drive(2'b01, 8'h00, 8'h01, 8'h01, 1'b0); tick();
        chk("c3_q",    q[3], 8'h01);
        chk("c3_qn",   qn[3], 8'hFF);
        chk("c3_val",  val[3], 8'hFE);
        chk("c3_conf", conf[3], 1'b1);
        chk("c3_cnt",  cnt[3], 4'd1);
        chk("c0_q",    q[0], 8'h00);
        chk("c0_qn",   qn[0], 8'hFF);
        chk("c1_q",    q[1], 8'h01);
        chk("c1_qn",   qn[1], 8'hFE);
        chk("c2_q",    q[2], 8'h01);
        chk("c2_qn",   qn[2], 8'hFE);

        drive(2'b00, 8'h00, 8'h00, 8'h00, 1'b0); tick();
        chk("recov_q",    q[3], 8'h01);
        chk("recov_qn",   qn[3], 8'hFE);
        chk("recov_val",  val[3], 8'hFF);
        chk("recov_conf", conf[3], 1'b0);
        chk("recov_cnt",  cnt[3], 4'd1);

        drive(2'b01, 8'h00, 8'h00, 8'h00, 1'b0); tick();
        drive(2'b01, 8'h00, 8'h01, 8'h01, 1'b0); tick();
        chk("c2b_q",  q[2], 8'h00);
        chk("c2b_qn", qn[2], 8'hFF);
        chk("c1b_q",  q[1], 8'h01);
        chk("c3b_cnt", cnt[3], 4'd2);

        drive(2'b00, 8'h00, 8'h01, 8'h01, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt", cnt[3], 4'd15);
        tick();
        chk("sat_hold", cnt[3], 4'd15);
        chk("sat_cnt_c0", cnt[0], 4'd15);

        CLR_CNT = 1'b1; tick();
        chk("clr_cnt",  cnt[3], 4'd0);
        chk("clr_conf", conf[3], 1'b1);
        CLR_CNT = 1'b0; tick();
        chk("post_clr_cnt", cnt[3], 4'd1);

        // Bit 0 sits at (1,1); its Q=1 shifts into bit 1
        drive(2'b10, 8'h00, 8'h00, 8'h00, 1'b0); tick();
        chk("shl11_q",  q[3], 8'h02);
        chk("shl11_qn", qn[3], 8'hFD);

        drive(2'b01, 8'h3C, 8'h00, 8'h00, 1'b0); tick();
        drive(2'b10, 8'h00, 8'h00, 8'h00, 1'b1);
        #2 RN = 1'b0; #1;
        chk("rst_shift_q",   q[3], 8'h00);
        chk("rst_shift_cnt", cnt[3], 4'd0);
        @(posedge CLK); #1 RN = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
